// File: rtl/des_uart_host.sv
// -----------------------------------------------------------------------------
// des_uart_host
//
// Host-side initiator for the DES board-test UART link. A request (command byte
// plus 64-bit payload) is serialised as a 9-byte frame on uart_tx: the command
// first, then the payload LSB byte first. For encrypt (8'h0F) and decrypt
// (8'hF0) the block then waits for an 8-byte reply on uart_rx and presents it
// as one 64-bit word. Any other command, including load key (8'hFF), finishes
// once the frame has been sent.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   req_valid    request present; accepted when req_valid && req_ready
//   req_ready    high only in IDLE (and not while rst is asserted)
//   req_cmd      command byte, sent unchanged as the first frame byte
//   req_data     64-bit key or data block, sent after the command
//   rsp_valid    one-cycle pulse; rsp_data holds the result
//   rsp_data     result word, held until the next rsp_valid
//   rsp_timeout  one-cycle pulse: the reply did not begin within TIMEOUT_BAUDS bit periods
//   rsp_err      one-cycle pulse: a reply byte had a stop bit of 0
//   busy         high from accept until the transaction ends
//   uart_tx      serial out, idle high
//   uart_rx      serial in, asynchronous (synchronised internally)
// -----------------------------------------------------------------------------
module des_uart_host #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD          = 9600,
  parameter int GAP_BITS      = 1,
  parameter int TIMEOUT_BAUDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [63:0] req_data,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_timeout,
  output logic        rsp_err,
  output logic        busy,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int MCNT_BAUD = CLK_FREQ / BAUD - 1;
  localparam int HALF_BIT  = (MCNT_BAUD + 1) / 2;
  localparam int BW        = (MCNT_BAUD > 0) ? $clog2(MCNT_BAUD + 1) : 1;
  localparam int TW        = (TIMEOUT_BAUDS > 1) ? $clog2(TIMEOUT_BAUDS) : 1;
  localparam int GW        = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [7:0] CMD_ENC = 8'h0F;
  localparam logic [7:0] CMD_DEC = 8'hF0;

  typedef enum logic [3:0] {
    IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_GAP,
    RX_WAIT,
    RX_START,
    RX_DATA,
    RX_STOP,
    DONE
  } state_t;

  state_t state, state_next;

  logic [BW-1:0] baud_cnt;   // clock within the current bit period
  logic [2:0]    bit_cnt;    // data bit index, tx and rx
  logic [GW-1:0] gap_cnt;    // idle bit periods already sent after a stop bit
  logic [3:0]    byte_cnt;   // tx: 0..8, rx: 0..7
  logic [71:0]   frame;      // {data, cmd}; frame[0] is the bit on the wire
  logic [7:0]    cmd_q;
  logic [7:0]    rx_shift;
  logic [55:0]   rsp_buf;    // reply bytes 0..6, byte 0 ends up in [7:0]
  logic [BW-1:0] tmo_div;    // bit-period prescaler for the reply timeout
  logic [TW-1:0] tmo_cnt;    // whole bit periods spent waiting in RX_WAIT
  logic          rx_s1, rx_s2, rx_s3;

  logic accept, baud_end, half_end, tmo_end, rx_fall, rx_store;
  logic tx_byte_done, expect_rsp;

  assign accept     = req_valid && req_ready;
  assign baud_end   = (baud_cnt == BW'(MCNT_BAUD));
  assign half_end   = (baud_cnt == BW'(HALF_BIT - 1));
  assign tmo_end    = (tmo_div == BW'(MCNT_BAUD)) && (tmo_cnt == TW'(TIMEOUT_BAUDS - 1));
  assign rx_fall    = rx_s3 && !rx_s2;
  assign rx_store   = (state == RX_STOP) && baud_end && rx_s2;
  assign expect_rsp = (cmd_q == CMD_ENC) || (cmd_q == CMD_DEC);

  // A byte is finished at the end of its last gap period, or at the end of
  // the stop bit when no gap is configured.
  assign tx_byte_done = baud_end &&
                        (((GAP_BITS == 0) && (state == TX_STOP)) ||
                         ((state == TX_GAP) && (gap_cnt == GW'(GAP_BITS - 1))));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (accept) state_next = TX_START;
      TX_START: if (baud_end) state_next = TX_DATA;
      TX_DATA:  if (baud_end && bit_cnt == 3'd7) state_next = TX_STOP;
      TX_STOP,
      TX_GAP: begin
        if (tx_byte_done) begin
          if (byte_cnt != 4'd8)  state_next = TX_START;
          else if (expect_rsp)   state_next = RX_WAIT;
          else                   state_next = IDLE;
        end else if (state == TX_STOP && baud_end) begin
          state_next = TX_GAP;
        end
      end
      RX_WAIT: begin
        if (tmo_end)      state_next = IDLE;
        else if (rx_fall) state_next = RX_START;
      end
      // A line that is high again at mid start bit was a glitch.
      RX_START: if (half_end) state_next = rx_s2 ? RX_WAIT : RX_DATA;
      RX_DATA:  if (baud_end && bit_cnt == 3'd7) state_next = RX_STOP;
      RX_STOP: begin
        if (baud_end) begin
          if (!rx_s2)                state_next = IDLE;
          else if (byte_cnt == 4'd7) state_next = DONE;
          else                       state_next = RX_WAIT;
        end
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from state
  // ---------------------------------------------------------------------------
  // DONE is the one-cycle handoff: rsp_valid is high and busy has already
  // dropped, so busy falls together with the pulse.
  always_comb begin
    uart_tx = 1'b1;
    unique case (state)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = frame[0];
      default:  uart_tx = 1'b1;
    endcase
    req_ready = (state == IDLE) && !rst;
    busy      = (state != IDLE) && (state != DONE);
    rsp_valid = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath: counters, shift registers, response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      byte_cnt    <= '0;
      frame       <= '0;
      cmd_q       <= '0;
      rx_shift    <= '0;
      rsp_buf     <= '0;
      rsp_data    <= '0;
      tmo_div     <= '0;
      tmo_cnt     <= '0;
      rsp_timeout <= 1'b0;
      rsp_err     <= 1'b0;
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_s3       <= 1'b1;
    end else begin
      // rx_s3 only serves falling-edge detection on the synchronised line.
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;

      // Every state change restarts the bit timer; within a state it wraps
      // at the end of each bit period.
      if (state_next != state || baud_end) baud_cnt <= '0;
      else                                 baud_cnt <= baud_cnt + 1'b1;

      if (state == TX_DATA || state == RX_DATA) begin
        if (baud_end) bit_cnt <= bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
      end

      if (state == TX_GAP) begin
        if (baud_end) gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end

      if (accept) begin
        frame    <= {req_data, req_cmd};
        cmd_q    <= req_cmd;
        byte_cnt <= '0;
      end else if (state == TX_DATA && baud_end) begin
        frame <= {1'b0, frame[71:1]};
      end

      if (tx_byte_done) byte_cnt <= (byte_cnt == 4'd8) ? 4'd0 : byte_cnt + 1'b1;

      // Sampling happens one bit period after the mid-start check, so each
      // data bit is taken near its centre.
      if (state == RX_DATA && baud_end) rx_shift <= {rx_s2, rx_shift[7:1]};

      if (rx_store) begin
        byte_cnt <= byte_cnt + 1'b1;
        if (byte_cnt == 4'd7) rsp_data <= {rx_shift, rsp_buf};
        else                  rsp_buf  <= {rx_shift, rsp_buf[55:8]};
      end

      // Timeout runs only while waiting for a start bit; a glitch back to
      // RX_WAIT continues the count, a stored byte restarts it.
      if (state == RX_WAIT) begin
        if (tmo_end) begin
          tmo_div <= '0;
          tmo_cnt <= '0;
        end else if (tmo_div == BW'(MCNT_BAUD)) begin
          tmo_div <= '0;
          tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
          tmo_div <= tmo_div + 1'b1;
        end
      end else if (rx_store || !(state inside {RX_START, RX_DATA, RX_STOP})) begin
        tmo_div <= '0;
        tmo_cnt <= '0;
      end

      rsp_timeout <= (state == RX_WAIT) && tmo_end;
      rsp_err     <= (state == RX_STOP) && baud_end && !rx_s2;
    end
  end

endmodule

// File: tb/tb_des_uart_host.sv
// -----------------------------------------------------------------------------
// tb_des_uart_host
//
// Directed bench for des_uart_host at 10 clocks per bit, one gap bit and a
// 16-bit-period reply timeout. The bench decodes uart_tx, plays the DES board
// replies on uart_rx and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_des_uart_host;

  localparam int CLK_FREQ      = 1_000_000;
  localparam int BAUD          = 100_000;
  localparam int GAP_BITS      = 1;
  localparam int TIMEOUT_BAUDS = 16;
  localparam int CPB           = 10;   // clocks per bit

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd = 8'h00;
  logic [63:0] req_data = 64'h0;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_timeout;
  logic        rsp_err;
  logic        busy;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  des_uart_host #(
    .CLK_FREQ      (CLK_FREQ),
    .BAUD          (BAUD),
    .GAP_BITS      (GAP_BITS),
    .TIMEOUT_BAUDS (TIMEOUT_BAUDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .uart_tx     (uart_tx),
    .uart_rx     (uart_rx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  int          n_valid = 0, n_tmo = 0, n_err = 0;
  int          tmo_cyc = 0;
  logic [63:0] last_rsp = 64'h0;
  logic        busy_at_valid = 1'b1;

  always @(negedge clk) begin
    if (rsp_valid) begin
      n_valid++;
      last_rsp      = rsp_data;
      busy_at_valid = busy;
    end
    if (rsp_timeout) begin
      n_tmo++;
      tmo_cyc = cyc;
    end
    if (rsp_err) n_err++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge one cycle later
  // (first cycle after the accepting edge).
  task automatic send_req(input logic [7:0] c, input logic [63:0] d);
    int n = 0;
    while (req_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_accept", {63'h0, req_ready}, 64'h1);
    req_cmd   = c;
    req_data  = d;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  // Decode one byte from uart_tx, sampling each bit at its centre.
  task automatic get_tx_byte(output logic [7:0] b, output bit ok);
    int n = 0;
    b  = 8'h00;
    ok = 1'b1;
    while (uart_tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      ok = 1'b0;
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    if (uart_tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (CPB) @(negedge clk);
    if (uart_tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic get_tx_frame(output logic [7:0] c, output logic [63:0] d, output bit ok);
    logic [7:0] b;
    bit         bok;
    ok = 1'b1;
    get_tx_byte(c, bok);
    ok &= bok;
    d = 64'h0;
    for (int k = 0; k < 8; k++) begin
      get_tx_byte(b, bok);
      ok &= bok;
      d[8*k +: 8] = b;
    end
  endtask

  task automatic send_rx_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Send the first n_bytes of rep; byte bad_idx gets a 0 stop bit.
  task automatic send_reply(input logic [7:0] rep [8], input int n_bytes, input int bad_idx);
    for (int k = 0; k < n_bytes; k++) send_rx_byte(rep[k], (k == bad_idx) ? 1'b0 : 1'b1);
  endtask

  logic [7:0]  got_cmd;
  logic [63:0] got_data;
  bit          frame_ok;
  logic [7:0]  rep [8];
  int          v0, t0, e0, n;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_uart_tx",     {63'h0, uart_tx},     64'h1);
    check("rst_req_ready",   {63'h0, req_ready},   64'h0);
    check("rst_rsp_valid",   {63'h0, rsp_valid},   64'h0);
    check("rst_rsp_timeout", {63'h0, rsp_timeout}, 64'h0);
    check("rst_rsp_err",     {63'h0, rsp_err},     64'h0);
    check("rst_busy",        {63'h0, busy},        64'h0);
    check("rst_rsp_data",    rsp_data,             64'h0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {63'h0, req_ready},   64'h1);
    @(negedge clk);

    // ---------------- 1: encrypt with reply ----------------
    send_req(8'h0F, 64'h0123456789ABCDEF);
    check("t1_tx_start_low", {63'h0, uart_tx},   64'h0);
    check("t1_busy",         {63'h0, busy},      64'h1);
    check("t1_not_ready",    {63'h0, req_ready}, 64'h0);
    get_tx_frame(got_cmd, got_data, frame_ok);
    check("t1_frame_ok", {63'h0, frame_ok}, 64'h1);
    check("t1_tx_cmd",   {56'h0, got_cmd},  64'h0F);
    check("t1_tx_data",  got_data,          64'h0123456789ABCDEF);
    repeat (20) @(negedge clk);
    rep = '{8'h05, 8'hB4, 8'h0A, 8'h0F, 8'h54, 8'h13, 8'hE8, 8'h85};
    send_reply(rep, 8, -1);
    repeat (5) @(negedge clk);
    check("t1_valid_count",  n_valid,                  1);
    check("t1_rsp_pulse",    last_rsp,                 64'h85E813540F0AB405);
    check("t1_rsp_data",     rsp_data,                 64'h85E813540F0AB405);
    check("t1_busy_at_vld",  {63'h0, busy_at_valid},   64'h0);
    check("t1_no_err_tmo",   n_err + n_tmo,            0);
    check("t1_idle_ready",   {63'h0, req_ready},       64'h1);

    // ---------------- 2: load key, no reply ----------------
    v0 = n_valid; t0 = n_tmo; e0 = n_err;
    send_req(8'hFF, 64'h133457799BBCDFF1);
    get_tx_frame(got_cmd, got_data, frame_ok);
    check("t2_frame_ok", {63'h0, frame_ok}, 64'h1);
    check("t2_tx_cmd",   {56'h0, got_cmd},  64'hFF);
    check("t2_tx_data",  got_data,          64'h133457799BBCDFF1);
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t2_ready_time", cyc - acc_cyc, 990);
    check("t2_busy_low",   {63'h0, busy}, 64'h0);
    repeat (200) @(negedge clk);
    check("t2_no_pulses", (n_valid - v0) + (n_tmo - t0) + (n_err - e0), 0);

    // ---------------- 3: decrypt, no reply -> timeout ----------------
    v0 = n_valid; t0 = n_tmo;
    send_req(8'hF0, 64'h0011223344556677);
    n = 0;
    while (n_tmo == t0 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check("t3_tmo_count", n_tmo - t0,          1);
    check("t3_tmo_time",  tmo_cyc - acc_cyc,   990 + 160);
    repeat (3) @(negedge clk);
    check("t3_no_valid",  n_valid - v0,        0);
    check("t3_data_held", rsp_data,            64'h85E813540F0AB405);
    check("t3_idle",      {63'h0, req_ready},  64'h1);

    // ---------------- 4: bad stop bit on reply byte 3 ----------------
    v0 = n_valid; e0 = n_err;
    send_req(8'h0F, 64'hA5A5A5A5A5A5A5A5);
    repeat (999) @(negedge clk);
    rep = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    send_reply(rep, 4, 3);
    repeat (5) @(negedge clk);
    check("t4_err_count", n_err - e0,         1);
    check("t4_no_valid",  n_valid - v0,       0);
    check("t4_data_held", rsp_data,           64'h85E813540F0AB405);
    check("t4_idle",      {63'h0, req_ready}, 64'h1);

    // ---------------- 5: reset during tx byte 3 ----------------
    v0 = n_valid; t0 = n_tmo; e0 = n_err;
    send_req(8'h0F, 64'h5555AAAA5555AAAA);
    repeat (350) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_tx_high",  {63'h0, uart_tx},   64'h1);
    check("t5_busy_low", {63'h0, busy},      64'h0);
    check("t5_ready",    {63'h0, req_ready}, 64'h1);
    @(negedge clk);
    repeat (300) @(negedge clk);
    check("t5_tx_idle",   {63'h0, uart_tx}, 64'h1);
    check("t5_no_pulses", (n_valid - v0) + (n_tmo - t0) + (n_err - e0), 0);
    send_req(8'h0F, 64'hFEDCBA9876543210);
    get_tx_frame(got_cmd, got_data, frame_ok);
    check("t5_frame_ok", {63'h0, frame_ok}, 64'h1);
    check("t5_tx_data",  got_data,          64'hFEDCBA9876543210);
    repeat (20) @(negedge clk);
    rep = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_reply(rep, 8, -1);
    repeat (5) @(negedge clk);
    check("t5_valid_count", n_valid - v0, 1);
    check("t5_rsp_data",    rsp_data,     64'h8877665544332211);

    // ---------------- 6: glitch in RX_WAIT, then real reply ----------------
    v0 = n_valid; t0 = n_tmo; e0 = n_err;
    send_req(8'hF0, 64'h0F1E2D3C4B5A6978);
    repeat (1005) @(negedge clk);
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    // A request while busy must be ignored.
    req_cmd   = 8'hFF;
    req_data  = 64'hDEADBEEFDEADBEEF;
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("t6_still_busy", {63'h0, busy}, 64'h1);
    rep = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    send_reply(rep, 8, -1);
    repeat (5) @(negedge clk);
    check("t6_valid_count", n_valid - v0,             1);
    check("t6_rsp_data",    rsp_data,                 64'h1807F6E5D4C3B2A1);
    check("t6_no_err_tmo",  (n_tmo - t0) + (n_err - e0), 0);
    check("t6_idle",        {63'h0, req_ready},       64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
